// File: rtl/array5_element_sequencer.sv
// Stream-to-array sequencer: gathers DEPTH elements into an operand array, strobes the
// array datapath once, captures its result after LAT cycles and streams the result back out.
module array5_element_sequencer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 5,
    parameter int LAT   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [WIDTH*DEPTH-1:0]   arr_I,
    output logic                     arr_start,
    input  logic [WIDTH*DEPTH-1:0]   arr_O,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] operand_reg [DEPTH];
    logic [WIDTH-1:0] result_reg  [DEPTH];

    logic in_fire;
    logic out_fire;
    logic capture;

    assign in_fire  = (state_reg == FILL) && in_valid && !RESET;
    assign out_fire = (state_reg == DRAIN) && out_ready;
    assign capture  = (state_reg == WAIT) && (cnt_reg == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= FILL;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            FILL: begin
                if (in_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ISSUE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = CNT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = FILL;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
            end
        endcase
    end

    // Each element owns its register so only the addressed slot ever changes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    operand_reg[gi] <= '0;
                end else if (in_fire && (idx_reg == IW'(gi))) begin
                    operand_reg[gi] <= in_data;
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    result_reg[gi] <= '0;
                end else if (capture) begin
                    result_reg[gi] <= arr_O[gi*WIDTH +: WIDTH];
                end
            end

            assign arr_I[gi*WIDTH +: WIDTH] = operand_reg[gi];
        end
    endgenerate

    assign in_ready  = (state_reg == FILL) && !RESET;
    assign arr_start = (state_reg == ISSUE);
    assign out_valid = (state_reg == DRAIN);
    assign out_data  = result_reg[idx_reg];
    assign out_last  = (state_reg == DRAIN) && (idx_reg == LAST_IDX);
    assign busy      = (state_reg != FILL);

endmodule

// File: tb/tb_array5_element_sequencer.sv
// Bench for array5_element_sequencer with LAT=3 and a +1-per-element datapath model whose
// result is present on arr_O only during the single cycle exactly LAT cycles after issue.
module tb_array5_element_sequencer;

    localparam int W = 5;
    localparam int D = 5;
    localparam int L = 3;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [W*D-1:0]   arr_I;
    logic             arr_start;
    logic [W*D-1:0]   arr_O;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q [$];

    array5_element_sequencer #(.WIDTH(W), .DEPTH(D), .LAT(L)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .arr_I     (arr_I),
        .arr_start (arr_start),
        .arr_O     (arr_O),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W*D-1:0] plus_one(input logic [W*D-1:0] a);
        logic [W*D-1:0] r;
        for (int k = 0; k < D; k++) r[k*W +: W] = a[k*W +: W] + 5'd1;
        return r;
    endfunction

    // Datapath model: three-stage pipe, zero outside the one valid cycle.
    logic [W*D-1:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge CLK) begin
        p1 <= arr_start ? plus_one(arr_I) : '0;
        p2 <= p1;
        p3 <= p2;
    end
    assign arr_O = p3;

    function automatic logic [W*D-1:0] pack(input logic [W-1:0] v [D]);
        logic [W*D-1:0] r;
        for (int k = 0; k < D; k++) r[k*W +: W] = v[k];
        return r;
    endfunction

    // Drives D accepted beats (valid every gap-th cycle) and pushes expected results.
    // Returns at the negedge following the last accept, i.e. in ISSUE.
    task automatic do_fill(input logic [W-1:0] vals [D], input int gap);
        int k = 0;
        int cyc = 0;
        while (k < D && cyc < 200) begin
            @(negedge CLK);
            if (cyc % gap == 0) begin
                in_valid = 1'b1;
                in_data  = vals[k];
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(vals[k] + 5'd1);
                k++;
            end
            cyc++;
        end
        checks++;
        if (k != D) begin
            errors++;
            $display("FAIL fill_timeout accepted=%0d required=%0d", k, D);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // Pops the scoreboard as out_valid beats are accepted under a cyclic ready pattern.
    task automatic do_drain(input logic [7:0] pat, input int plen);
        int i = 0;
        int guard = 0;
        logic [W-1:0] held = '0;
        logic stalled = 1'b0;
        while (exp_q.size() > 0 && guard < 200) begin
            if (out_valid) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL drain_data got=%0d expected=%0d", out_data, exp_q[0]);
                end
                checks++;
                if (out_last !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL drain_last got=%0b expected=%0b", out_last, exp_q.size() == 1);
                end
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold got=%0d expected=%0d", out_data, held);
                    end
                end
                out_ready = pat[i % plen];
                i++;
                if (out_ready) begin
                    $display("drain element=%0d last=%0b", out_data, out_last);
                    void'(exp_q.pop_front());
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge CLK);
            guard++;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_fill busy=%0b in_ready=%0b out_valid=%0b required 0 1 0",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || arr_start !== 1'b0 || in_ready !== 1'b0 ||
            out_last !== 1'b0 || arr_I !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%0b ov=%0b start=%0b ir=%0b last=%0b arr_I=%h required all 0",
                     busy, out_valid, arr_start, in_ready, out_last, arr_I);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%0b required=1", in_ready);
        end
        $display("reset done in_ready=%0b busy=%0b", in_ready, busy);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v [D];
        int n;
        v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        do_fill(v, 1);
        checks++;
        if (arr_start !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_issue arr_start=%0b in_ready=%0b required 1 0", arr_start, in_ready);
        end
        checks++;
        if (arr_I !== 25'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1})) begin
            errors++;
            $display("FAIL b2b_arr_I got=%h required=%h", arr_I, 25'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!out_valid && n < 20);
        checks++;
        if (n != L + 1) begin
            errors++;
            $display("FAIL latency cycles=%0d required=%0d", n, L + 1);
        end
        $display("b2b arr_I=%h first out_valid after %0d cycles", arr_I, n);
        do_drain(8'b1, 1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [D];
        v = '{5'd31, 5'd0, 5'd15, 5'd16, 5'd1};
        do_fill(v, 1);
        checks++;
        if (arr_I !== pack(v)) begin
            errors++;
            $display("FAIL bp_arr_I got=%h required=%h", arr_I, pack(v));
        end
        do_drain(8'b1001, 4);
        $display("backpressure drain complete");
    endtask

    task automatic test_input_gaps();
        logic [W-1:0] v [D];
        v = '{5'd7, 5'd12, 5'd19, 5'd26, 5'd3};
        do_fill(v, 3);
        checks++;
        if (arr_start !== 1'b1) begin
            errors++;
            $display("FAIL gap_issue arr_start=%0b required=1", arr_start);
        end
        checks++;
        if (arr_I !== pack(v)) begin
            errors++;
            $display("FAIL gap_arr_I got=%h required=%h", arr_I, pack(v));
        end
        @(negedge CLK);
        checks++;
        if (arr_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_single_strobe arr_start=%0b busy=%0b required 0 1", arr_start, busy);
        end
        do_drain(8'b110, 3);
        $display("input gaps arr_I=%h", pack(v));
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] v [D];
        logic [W-1:0] f [D];
        v = '{5'd10, 5'd20, 5'd30, 5'd7, 5'd31};
        f = '{5'd9, 5'd8, 5'd6, 5'd4, 5'd2};
        do_fill(v, 1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || arr_I !== '0) begin
            errors++;
            $display("FAIL midreset_state busy=%0b ov=%0b ir=%0b arr_I=%h required 0 0 0 0",
                     busy, out_valid, in_ready, arr_I);
        end
        RESET = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_output out_valid=%0b busy=%0b required 0 0", out_valid, busy);
            end
        end
        do_fill(f, 1);
        checks++;
        if (arr_I !== pack(f)) begin
            errors++;
            $display("FAIL midreset_arr_I got=%h required=%h", arr_I, pack(f));
        end
        do_drain(8'b1, 1);
        $display("mid-op reset recovery complete");
    endtask

    initial begin
        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_input_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
